pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of refclk cycles the PLL reset is held per attempt (range 2..255).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before the system is released (range 2..65535).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 50000: refclk cycles allowed in WAIT_LOCK per attempt (range 2..2^20-1).
REQ-004 Parameter MAX_RETRIES, default 3: number of timed-out attempts before FAIL (range 1..15).
REQ-005 refclk  input  1  sole clock, 50 MHz reference; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 pll_locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 force_relock  input  1  single-cycle request to re-sequence the PLL.
REQ-009 pll_rst  output  1  reset to the PLL, active-high.
REQ-010 sys_rst  output  1  reset request to downstream clock domains, active-high.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 retry_cnt  output  4  timed-out attempts in the current episode.
REQ-014 state  output  3  encoding RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; "lock" below means the synchronizer output (2-cycle latency).
REQ-016 All outputs SHALL be registered and decoded from the current state: pll_rst=1 in RESET_PLL and FAIL; sys_rst=0 only in RUN.
REQ-017 RESET_PLL SHALL last exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-018 WAIT_LOCK: lock=1 SHALL go to STABLE with the stable counter cleared.
REQ-019 WAIT_LOCK: after LOCK_TIMEOUT_CYCLES cycles without lock, retry_cnt SHALL increment; if the new value equals MAX_RETRIES go to FAIL, else go to RESET_PLL.
REQ-020 STABLE: lock=0 SHALL return to WAIT_LOCK with the timeout counter cleared and retry_cnt unchanged.
REQ-021 STABLE: after LOCK_STABLE_CYCLES consecutive lock=1 cycles, the block SHALL go to RUN; sys_rst falls and ready rises on the same edge.
REQ-022 RUN: lock=0 SHALL go to RESET_PLL, clearing retry_cnt; sys_rst rises on the next edge.
REQ-023 FAIL SHALL be held until force_relock or rst; counters frozen.
REQ-024 force_relock=1 in any state except RESET_PLL SHALL go to RESET_PLL and clear retry_cnt; in RESET_PLL it SHALL restart the RST_CYCLES count.
REQ-025 force_relock SHALL take priority over any simultaneous lock, timeout or stable event.
REQ-026 Counters SHALL saturate and never wrap; widths SHALL be derived from their parameters.

Reset
REQ-027 rst=1 SHALL asynchronously force state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, synchronizer=0, all counters 0.
REQ-028 After rst deasserts, the RESET_PLL count SHALL begin on the first rising edge; rst asserted mid-sequence SHALL abort it with no residual state.

Configuration
REQ-029 Macro PLL_SEQ_TIMEOUT_EN defined: timeout, retry counting and FAIL exist as in REQ-019/023.
REQ-030 Macro PLL_SEQ_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely, FAIL unreachable, fail tied 0, retry_cnt tied 0, timeout counter removed.

Verification (RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-031 rst released, pll_locked rises 10 cycles later and stays high -> pll_rst high 4 cycles, RUN reached 2+8 cycles after lock enters WAIT_LOCK path, sys_rst=0, ready=1.
REQ-032 pll_locked held 0 -> two 32-cycle WAIT_LOCK windows, retry_cnt 1 then 2, state=4, fail=1, pll_rst=1 held 100 cycles.
REQ-033 lock glitches low for 1 cycle at stable count 5 -> back to WAIT_LOCK, then full 8 fresh cycles before RUN, retry_cnt unchanged.
REQ-034 In RUN, pll_locked drops -> sys_rst=1 and state=0 within 3 cycles, retry_cnt=0, RUN re-entered after relock.
REQ-035 force_relock in FAIL, coincident with a timeout in WAIT_LOCK, and in RESET_PLL -> state=0, retry_cnt=0, full 4-cycle pll_rst each time.
REQ-036 Build with PLL_SEQ_TIMEOUT_EN undefined, pll_locked low 1000 cycles -> state stays 1, fail=0, retry_cnt=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for a synchronized lock,
// qualifies it for a stable window, then releases downstream clock domains.
// Build option: define PLL_SEQ_TIMEOUT_EN to enable the WAIT_LOCK timeout,
// retry counting and the FAIL state. Undefined, WAIT_LOCK waits indefinitely.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    // Counters only ever reach PARAM-1, so $clog2(PARAM) bits suffice.
    localparam int unsigned RST_W = $clog2(RST_CYCLES);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES);

    // Elaboration-time parameter range checks.
    if (RST_CYCLES < 2 || RST_CYCLES > 255) begin : g_chk_rst
        $error("RST_CYCLES out of range");
    end
    if (LOCK_STABLE_CYCLES < 2 || LOCK_STABLE_CYCLES > 65535) begin : g_chk_stb
        $error("LOCK_STABLE_CYCLES out of range");
    end
    if (LOCK_TIMEOUT_CYCLES < 2 || LOCK_TIMEOUT_CYCLES > 1048575) begin : g_chk_tmo
        $error("LOCK_TIMEOUT_CYCLES out of range");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_chk_retry
        $error("MAX_RETRIES out of range");
    end

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;
    logic               sync_q1;
    logic               lock;
    logic [RST_W-1:0]   rst_cnt;
    logic [RST_W-1:0]   rst_cnt_nxt;
    logic [STB_W-1:0]   stb_cnt;
    logic [STB_W-1:0]   stb_cnt_nxt;
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYCLES);
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_nxt;
    logic [3:0]         retry_nxt;
`endif

    assign state = 3'(cur_state);

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            lock    <= 1'b0;
        end else begin
            sync_q1 <= pll_locked;
            lock    <= sync_q1;
        end
    end

    // Next-state and counter update; force_relock overrides every other event.
    always_comb begin
        nxt_state   = cur_state;
        rst_cnt_nxt = rst_cnt;
        stb_cnt_nxt = stb_cnt;
`ifdef PLL_SEQ_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt;
        retry_nxt   = retry_cnt;
`endif
        if (force_relock) begin
            nxt_state   = S_RESET_PLL;
            rst_cnt_nxt = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_nxt   = '0;
`endif
        end else begin
            case (cur_state)
                S_RESET_PLL: begin
                    if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        nxt_state   = S_WAIT_LOCK;
`ifdef PLL_SEQ_TIMEOUT_EN
                        tmo_cnt_nxt = '0;
`endif
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock) begin
                        nxt_state   = S_STABLE;
                        stb_cnt_nxt = '0;
                    end
`ifdef PLL_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_nxt = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
                        if (retry_nxt == 4'(MAX_RETRIES)) begin
                            nxt_state = S_FAIL;
                        end else begin
                            nxt_state   = S_RESET_PLL;
                            rst_cnt_nxt = '0;
                        end
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
`endif
                end
                S_STABLE: begin
                    // The stable window counts cycles spent in STABLE with lock high.
                    if (!lock) begin
                        nxt_state   = S_WAIT_LOCK;
`ifdef PLL_SEQ_TIMEOUT_EN
                        tmo_cnt_nxt = '0;
`endif
                    end else if (stb_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        nxt_state = S_RUN;
                    end else begin
                        stb_cnt_nxt = stb_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock) begin
                        nxt_state   = S_RESET_PLL;
                        rst_cnt_nxt = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
                        retry_nxt   = '0;
`endif
                    end
                end
                S_FAIL: begin
                    nxt_state = S_FAIL;
                end
                default: begin
                    nxt_state   = S_RESET_PLL;
                    rst_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs decode the state being entered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur_state <= S_RESET_PLL;
            rst_cnt   <= '0;
            stb_cnt   <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            fail      <= 1'b0;
`endif
        end else begin
            cur_state <= nxt_state;
            rst_cnt   <= rst_cnt_nxt;
            stb_cnt   <= stb_cnt_nxt;
            pll_rst   <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
            sys_rst   <= (nxt_state != S_RUN);
            ready     <= (nxt_state == S_RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nxt;
            retry_cnt <= retry_nxt;
            fail      <= (nxt_state == S_FAIL);
`endif
        end
    end

`ifndef PLL_SEQ_TIMEOUT_EN
    assign fail      = 1'b0;
    assign retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (RST=4, STABLE=8, TIMEOUT=32, RETRIES=2).
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .state        (state)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, returning at the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Pulse force_relock so exactly one rising edge samples it.
    task automatic pulse_force();
        force_relock = 1'b1;
        cyc(1);
        force_relock = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        cyc(2);
        chk("rst_state",   32'(state),     32'd0);
        chk("rst_pll_rst", 32'(pll_rst),   32'd1);
        chk("rst_sys_rst", 32'(sys_rst),   32'd1);
        chk("rst_ready",   32'(ready),     32'd0);
        chk("rst_fail",    32'(fail),      32'd0);
        chk("rst_retry",   32'(retry_cnt), 32'd0);

        // Basic bring-up: PLL reset held exactly 4 cycles, lock 10 cycles after release.
        rst = 1'b0;
        cyc(3);
        chk("up_e3_state",   32'(state),   32'd0);
        chk("up_e3_pll_rst", 32'(pll_rst), 32'd1);
        cyc(1);
        chk("up_e4_state",   32'(state),   32'd1);
        chk("up_e4_pll_rst", 32'(pll_rst), 32'd0);
        cyc(6);
        pll_locked = 1'b1;
        cyc(2);
        chk("up_sync_lat",   32'(state),   32'd1);
        cyc(1);
        chk("up_stable",     32'(state),   32'd2);
        cyc(7);
        chk("up_stable_end", 32'(state),   32'd2);
        chk("up_sysrst_hi",  32'(sys_rst), 32'd1);
        cyc(1);
        chk("up_run_state",  32'(state),   32'd3);
        chk("up_run_ready",  32'(ready),   32'd1);
        chk("up_run_sysrst", 32'(sys_rst), 32'd0);
        chk("up_run_pllrst", 32'(pll_rst), 32'd0);

        // Lock loss in RUN: two sync cycles then RESET_PLL on the third edge.
        pll_locked = 1'b0;
        cyc(2);
        chk("loss_still_run", 32'(state),     32'd3);
        pll_locked = 1'b1;
        cyc(1);
        chk("loss_state",     32'(state),     32'd0);
        chk("loss_sys_rst",   32'(sys_rst),   32'd1);
        chk("loss_ready",     32'(ready),     32'd0);
        chk("loss_retry",     32'(retry_cnt), 32'd0);
        cyc(3);
        chk("relock_rstpll",  32'(state),     32'd0);
        cyc(1);
        chk("relock_wait",    32'(state),     32'd1);
        cyc(1);
        chk("relock_stable",  32'(state),     32'd2);
        cyc(7);
        chk("relock_st_end",  32'(state),     32'd2);
        cyc(1);
        chk("relock_run",     32'(state),     32'd3);

        // force_relock from RUN, then a one-cycle lock glitch at stable count 5.
        pulse_force();
        chk("frun_state",   32'(state),   32'd0);
        chk("frun_sys_rst", 32'(sys_rst), 32'd1);
        chk("frun_pll_rst", 32'(pll_rst), 32'd1);
        cyc(3);
        chk("frun_e4",      32'(state),   32'd0);
        cyc(1);
        chk("frun_wait",    32'(state),   32'd1);
        cyc(1);
        chk("gl_stable",    32'(state),   32'd2);
        cyc(3);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        cyc(1);
        chk("gl_cnt5",      32'(state),     32'd2);
        cyc(1);
        chk("gl_to_wait",   32'(state),     32'd1);
        chk("gl_retry",     32'(retry_cnt), 32'd0);
        cyc(1);
        chk("gl_restable",  32'(state),     32'd2);
        cyc(7);
        chk("gl_fresh7",    32'(state),     32'd2);
        chk("gl_fresh_rdy", 32'(ready),     32'd0);
        cyc(1);
        chk("gl_run",       32'(state),     32'd3);

        // force_relock inside RESET_PLL restarts the 4-cycle count.
        pulse_force();
        chk("frst_enter",   32'(state),   32'd0);
        cyc(2);
        pulse_force();
        chk("frst_restart", 32'(state),   32'd0);
        cyc(3);
        chk("frst_e4",      32'(state),   32'd0);
        chk("frst_pllrst",  32'(pll_rst), 32'd1);
        cyc(1);
        chk("frst_wait",    32'(state),   32'd1);
        chk("frst_pll_lo",  32'(pll_rst), 32'd0);
        cyc(1);
        chk("frst_stable",  32'(state),   32'd2);

        // Asynchronous reset mid-sequence aborts immediately.
        rst = 1'b1;
        #1;
        chk("arst_state",   32'(state),   32'd0);
        chk("arst_pll_rst", 32'(pll_rst), 32'd1);
        chk("arst_sys_rst", 32'(sys_rst), 32'd1);
        pll_locked = 1'b0;
        cyc(2);

`ifdef PLL_SEQ_TIMEOUT_EN
        // Lock never arrives: two 32-cycle windows, then FAIL.
        rst = 1'b0;
        cyc(4);
        chk("to_wait1",     32'(state),     32'd1);
        cyc(31);
        chk("to_w1_end",    32'(state),     32'd1);
        chk("to_w1_retry",  32'(retry_cnt), 32'd0);
        cyc(1);
        chk("to_retry1_st", 32'(state),     32'd0);
        chk("to_retry1",    32'(retry_cnt), 32'd1);
        chk("to_retry1_pr", 32'(pll_rst),   32'd1);
        cyc(3);
        chk("to_rst2",      32'(state),     32'd0);
        cyc(1);
        chk("to_wait2",     32'(state),     32'd1);
        cyc(31);
        chk("to_w2_end",    32'(state),     32'd1);
        chk("to_w2_retry",  32'(retry_cnt), 32'd1);
        cyc(1);
        chk("fail_state",   32'(state),     32'd4);
        chk("fail_flag",    32'(fail),      32'd1);
        chk("fail_retry",   32'(retry_cnt), 32'd2);
        chk("fail_pll_rst", 32'(pll_rst),   32'd1);
        cyc(100);
        chk("fail_hold_st", 32'(state),     32'd4);
        chk("fail_hold_fl", 32'(fail),      32'd1);
        chk("fail_hold_pr", 32'(pll_rst),   32'd1);
        chk("fail_hold_rc", 32'(retry_cnt), 32'd2);
        chk("fail_hold_sr", 32'(sys_rst),   32'd1);

        // force_relock out of FAIL.
        pulse_force();
        chk("ffail_state",  32'(state),     32'd0);
        chk("ffail_retry",  32'(retry_cnt), 32'd0);
        chk("ffail_flag",   32'(fail),      32'd0);
        cyc(3);
        chk("ffail_e4",     32'(state),     32'd0);
        cyc(1);
        chk("ffail_wait",   32'(state),     32'd1);

        // force_relock coincident with the timeout edge wins.
        cyc(31);
        chk("fto_pre",      32'(state),     32'd1);
        pulse_force();
        chk("fto_state",    32'(state),     32'd0);
        chk("fto_retry",    32'(retry_cnt), 32'd0);
        chk("fto_fail",     32'(fail),      32'd0);
        cyc(3);
        chk("fto_e4",       32'(state),     32'd0);
        cyc(1);
        chk("fto_wait",     32'(state),     32'd1);
        chk("fto_retry2",   32'(retry_cnt), 32'd0);
`else
        // Without the timeout option WAIT_LOCK waits forever.
        rst = 1'b0;
        cyc(4);
        chk("nto_wait",     32'(state),     32'd1);
        cyc(1000);
        chk("nto_state",    32'(state),     32'd1);
        chk("nto_fail",     32'(fail),      32'd0);
        chk("nto_retry",    32'(retry_cnt), 32'd0);
        chk("nto_pll_rst",  32'(pll_rst),   32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
